// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM responder state encoding.
// Imported by the SRAM slave and its byte-enable helper.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_WR_STALL,
        ST_ERR1,
        ST_ERR2
    } sram_state_t;

endpackage

// File: rtl/ahb_sram_be_gen.sv
// Little-endian byte-enable generator for 32-bit AHB data lanes.
// Flags HALF/WORD transfers whose offset breaks natural alignment.
module ahb_sram_be_gen
    import ahb_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] off,
    output logic [3:0] be,
    output logic       misaligned
);

    // Lane mask and alignment check from transfer size and byte offset
    always_comb begin
        be         = 4'b0000;
        misaligned = 1'b0;
        case (size)
            HSIZE_BYTE: begin
                be = 4'b0001 << off;
            end
            HSIZE_HALF: begin
                be         = 4'b0011 << off;
                misaligned = off[0];
            end
            HSIZE_WORD: begin
                be         = 4'b1111;
                misaligned = (off != 2'b00);
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder driving a single-port synchronous 32-bit SRAM.
// Optional write protection below WPROT_TOP: define AHB_SRAM_WPROT_EN.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter int          SRAM_AW   = 10,
    parameter logic [31:0] WPROT_TOP = 32'h0000_0100
) (
    input  logic               hclk,
    input  logic               rst,
    input  logic               hsel,
    input  logic [31:0]        haddr,
    input  logic               hwrite,
    input  logic [1:0]         htrans,
    input  logic [2:0]         hsize,
    input  logic [2:0]         hburst,
    input  logic [31:0]        hwdata,
    input  logic               hready,
    output logic               hreadyout,
    output logic               hresp,
    output logic [31:0]        hrdata,
    output logic               sram_cs,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [3:0]         sram_be,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata
);

    sram_state_t        state;
    sram_state_t        state_nxt;
    sram_state_t        acc_nxt;

    logic [SRAM_AW-1:0] wr_addr;
    logic [2:0]         wr_size;
    logic [1:0]         wr_off;
    logic [31:0]        rdata_q;

    logic [3:0]         live_be;
    logic               live_mis;
    logic [3:0]         wr_be;
    logic               wr_mis;

    logic               acc;
    logic               bad_size;
    logic               oob;
    logic               wprot;
    logic               illegal;
    logic               rd_req;
    logic               rd_acc;
    logic               wr_acc;
    logic               err_acc;
    logic               unused;

    ahb_sram_be_gen u_live_be (
        .size       (hsize),
        .off        (haddr[1:0]),
        .be         (live_be),
        .misaligned (live_mis)
    );

    ahb_sram_be_gen u_wr_be (
        .size       (wr_size),
        .off        (wr_off),
        .be         (wr_be),
        .misaligned (wr_mis)
    );

    assign acc      = hsel & htrans[1] & hready;
    assign bad_size = (hsize > HSIZE_WORD);
    assign oob      = ({2'b00, haddr[31:2]} >= 32'(MEM_WORDS));

`ifdef AHB_SRAM_WPROT_EN
    assign wprot = hwrite & (haddr < WPROT_TOP);
`else
    assign wprot = 1'b0;
`endif

    assign illegal = bad_size | live_mis | oob | wprot;
    assign rd_acc  = acc & ~hwrite & ~illegal;
    assign wr_acc  = acc & hwrite & ~illegal;
    assign err_acc = acc & illegal;

    // A pending read seen while the write owns the SRAM; hready is
    // deliberately left out so hreadyout never loops back on itself.
    assign rd_req = hsel & htrans[1] & ~hwrite & ~illegal;

    assign unused = ^{hburst, live_be, wr_mis, WPROT_TOP};

    // Data-phase state chosen by the transfer accepted this cycle
    always_comb begin
        acc_nxt = ST_IDLE;
        unique case (1'b1)
            err_acc: acc_nxt = ST_ERR1;
            wr_acc:  acc_nxt = ST_WR_DATA;
            rd_acc:  acc_nxt = ST_RD_DATA;
            default: acc_nxt = ST_IDLE;
        endcase
    end

    // Next state and bus response
    always_comb begin
        state_nxt = acc_nxt;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (state)
            ST_WR_DATA: begin
                if (rd_req) begin
                    hreadyout = 1'b0;
                    state_nxt = ST_WR_STALL;
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                hresp = HRESP_ERROR;
            end
            default: begin
                state_nxt = acc_nxt;
            end
        endcase
        if (rst) begin
            hreadyout = 1'b1;
            hresp     = HRESP_OKAY;
        end
    end

    // SRAM port: write data phase has priority, else a fresh read
    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = haddr[SRAM_AW+1:2];
        sram_be    = 4'b0000;
        sram_wdata = hwdata;
        if (state == ST_WR_DATA) begin
            sram_cs   = 1'b1;
            sram_we   = 1'b1;
            sram_addr = wr_addr;
            sram_be   = wr_be;
        end else if (rd_acc) begin
            sram_cs = 1'b1;
            sram_be = 4'b1111;
        end
        if (rst) begin
            sram_cs = 1'b0;
            sram_we = 1'b0;
            sram_be = 4'b0000;
        end
    end

    // State register
    always_ff @(posedge hclk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture write address phase for the following data phase
    always_ff @(posedge hclk) begin
        if (rst) begin
            wr_addr <= '0;
            wr_size <= 3'b000;
            wr_off  <= 2'b00;
        end else if (wr_acc) begin
            wr_addr <= haddr[SRAM_AW+1:2];
            wr_size <= hsize;
            wr_off  <= haddr[1:0];
        end
    end

    // Hold last read data outside the read data phase
    always_ff @(posedge hclk) begin
        if (rst) begin
            rdata_q <= 32'h0;
        end else if (state == ST_RD_DATA) begin
            rdata_q <= sram_rdata;
        end
    end

    assign hrdata = (state == ST_RD_DATA) ? sram_rdata : rdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave with a behavioural SRAM.
// Addresses shift above the protected region when AHB_SRAM_WPROT_EN.
module tb_ahb_sram_slave;

    logic        hclk;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        sram_cs;
    logic        sram_we;
    logic [9:0]  sram_addr;
    logic [3:0]  sram_be;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    logic [31:0] mem [0:1023];

    int n_chk  = 0;
    int n_pass = 0;

`ifdef AHB_SRAM_WPROT_EN
    localparam logic [31:0] B = 32'h0000_0100;
`else
    localparam logic [31:0] B = 32'h0000_0000;
`endif

    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    ahb_sram_slave dut (
        .hclk       (hclk),
        .rst        (rst),
        .hsel       (hsel),
        .haddr      (haddr),
        .hwrite     (hwrite),
        .htrans     (htrans),
        .hsize      (hsize),
        .hburst     (hburst),
        .hwdata     (hwdata),
        .hready     (hready),
        .hreadyout  (hreadyout),
        .hresp      (hresp),
        .hrdata     (hrdata),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_be    (sram_be),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    assign hready = hreadyout;

    always #5 hclk = ~hclk;

    always @(posedge hclk) begin
        if (sram_cs) begin
            if (sram_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (sram_be[i]) begin
                        mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
                    end
                end
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic ap(input logic w,
                      input logic [31:0] a,
                      input logic [2:0] s);
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = w;
        haddr  = a;
        hsize  = s;
    endtask

    task automatic idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr  = 32'h0;
        hsize  = 3'b000;
    endtask

    function automatic logic [31:0] wa(input logic [31:0] a);
        return a >> 2;
    endfunction

    initial begin
        hclk   = 1'b0;
        rst    = 1'b1;
        hburst = 3'b000;
        hwdata = 32'h0;
        idle();
        repeat (2) tick();
        settle();
        check("rst_rdy", 32'(hreadyout), 32'd1);
        check("rst_resp", 32'(hresp), 32'd0);
        check("rst_cs", 32'(sram_cs), 32'd0);
        check("rst_we", 32'(sram_we), 32'd0);
        check("rst_be", 32'(sram_be), 32'd0);
        rst = 1'b0;
        tick();

        // write word then read it back straight away: one wait state
        ap(1'b1, B + 32'h10, SW);
        settle();
        check("t1_ap_cs", 32'(sram_cs), 32'd0);
        tick();
        hwdata = 32'hDEAD_BEEF;
        ap(1'b0, B + 32'h10, SW);
        settle();
        check("t1_we", 32'(sram_we), 32'd1);
        check("t1_be", 32'(sram_be), 32'hF);
        check("t1_addr", 32'(sram_addr), wa(B + 32'h10));
        check("t1_wdata", sram_wdata, 32'hDEAD_BEEF);
        check("t1_col_rdy", 32'(hreadyout), 32'd0);
        tick();
        settle();
        check("t1_stall_rdy", 32'(hreadyout), 32'd1);
        check("t1_stall_we", 32'(sram_we), 32'd0);
        check("t1_stall_cs", 32'(sram_cs), 32'd1);
        tick();
        idle();
        settle();
        check("t1_rdata", hrdata, 32'hDEAD_BEEF);
        check("t1_resp", 32'(hresp), 32'd0);
        check("t1_rd_rdy", 32'(hreadyout), 32'd1);
        tick();

        // byte write into lane 3 of a preloaded word
        ap(1'b1, B + 32'h10, SW);
        tick();
        hwdata = 32'h1122_3344;
        ap(1'b1, B + 32'h13, SB);
        settle();
        check("t2_waw_rdy", 32'(hreadyout), 32'd1);
        tick();
        hwdata = 32'hAB00_0000;
        idle();
        settle();
        check("t2_be", 32'(sram_be), 32'b1000);
        tick();
        ap(1'b0, B + 32'h10, SW);
        settle();
        check("t2_rd_rdy", 32'(hreadyout), 32'd1);
        check("t2_rd_cs", 32'(sram_cs), 32'd1);
        tick();
        idle();
        settle();
        check("t2_rdata", hrdata, 32'hAB22_3344);
        tick();

        // out-of-range read: two-cycle error, no SRAM access
        ap(1'b0, 32'h0000_1000, SW);
        settle();
        check("t3r_ap_cs", 32'(sram_cs), 32'd0);
        tick();
        idle();
        settle();
        check("t3r_e1_rdy", 32'(hreadyout), 32'd0);
        check("t3r_e1_resp", 32'(hresp), 32'd1);
        check("t3r_e1_cs", 32'(sram_cs), 32'd0);
        tick();
        settle();
        check("t3r_e2_rdy", 32'(hreadyout), 32'd1);
        check("t3r_e2_resp", 32'(hresp), 32'd1);
        tick();
        settle();
        check("t3r_done", 32'(hresp), 32'd0);

        // misaligned word write
        ap(1'b1, B + 32'h22, SW);
        settle();
        check("t3w_ap_cs", 32'(sram_cs), 32'd0);
        tick();
        hwdata = 32'h9999_9999;
        idle();
        settle();
        check("t3w_e1_rdy", 32'(hreadyout), 32'd0);
        check("t3w_e1_resp", 32'(hresp), 32'd1);
        check("t3w_e1_we", 32'(sram_we), 32'd0);
        tick();
        settle();
        check("t3w_e2_rdy", 32'(hreadyout), 32'd1);
        check("t3w_e2_resp", 32'(hresp), 32'd1);
        tick();

        // oversize transfer is illegal too
        ap(1'b0, B, 3'b011);
        tick();
        idle();
        settle();
        check("t3s_resp", 32'(hresp), 32'd1);
        tick();
        tick();

        // BUSY is an OKAY no-op
        hsel   = 1'b1;
        htrans = 2'b01;
        haddr  = B;
        hsize  = SW;
        settle();
        check("busy_cs", 32'(sram_cs), 32'd0);
        check("busy_rdy", 32'(hreadyout), 32'd1);
        tick();
        idle();
        settle();
        check("busy_resp", 32'(hresp), 32'd0);
        tick();

        // back-to-back writes then reads
        ap(1'b1, B + 32'h0, SW);
        tick();
        hwdata = 32'hA0A0_0000;
        ap(1'b1, B + 32'h4, SW);
        settle();
        check("t4_w0_rdy", 32'(hreadyout), 32'd1);
        check("t4_w0_addr", 32'(sram_addr), wa(B));
        tick();
        hwdata = 32'h1111_2222;
        ap(1'b1, B + 32'h8, SW);
        settle();
        check("t4_w1_rdy", 32'(hreadyout), 32'd1);
        check("t4_w1_addr", 32'(sram_addr), wa(B + 32'h4));
        tick();
        hwdata = 32'hC2C2_C2C2;
        ap(1'b0, B + 32'h0, SW);
        settle();
        check("t4_w2_rdy", 32'(hreadyout), 32'd0);
        check("t4_w2_addr", 32'(sram_addr), wa(B + 32'h8));
        tick();
        settle();
        check("t4_st_rdy", 32'(hreadyout), 32'd1);
        check("t4_st_we", 32'(sram_we), 32'd0);
        check("t4_st_addr", 32'(sram_addr), wa(B));
        tick();
        ap(1'b0, B + 32'h4, SW);
        settle();
        check("t4_r0", hrdata, 32'hA0A0_0000);
        check("t4_r0_rdy", 32'(hreadyout), 32'd1);
        tick();
        ap(1'b0, B + 32'h8, SW);
        settle();
        check("t4_r1", hrdata, 32'h1111_2222);
        check("t4_r1_rdy", 32'(hreadyout), 32'd1);
        tick();
        idle();
        settle();
        check("t4_r2", hrdata, 32'hC2C2_C2C2);
        tick();
        settle();
        check("t4_hold", hrdata, 32'hC2C2_C2C2);
        tick();

        // halfword write to the upper lanes
        ap(1'b1, B + 32'h6, SH);
        tick();
        hwdata = 32'hBEEF_0000;
        idle();
        settle();
        check("th_be", 32'(sram_be), 32'b1100);
        tick();
        ap(1'b0, B + 32'h4, SW);
        tick();
        idle();
        settle();
        check("th_rdata", hrdata, 32'hBEEF_2222);
        tick();

        // reset during a write data phase drops the write
        ap(1'b1, B + 32'hC, SW);
        tick();
        hwdata = 32'h5555_AAAA;
        idle();
        tick();
        ap(1'b1, B + 32'hC, SW);
        tick();
        hwdata = 32'hFFFF_FFFF;
        idle();
        rst = 1'b1;
        settle();
        check("t5_rst_we", 32'(sram_we), 32'd0);
        check("t5_rst_rdy", 32'(hreadyout), 32'd1);
        check("t5_rst_resp", 32'(hresp), 32'd0);
        tick();
        rst = 1'b0;
        settle();
        check("t5_post_we", 32'(sram_we), 32'd0);
        check("t5_post_cs", 32'(sram_cs), 32'd0);
        tick();
        ap(1'b0, B + 32'hC, SW);
        tick();
        idle();
        settle();
        check("t5_keep", hrdata, 32'h5555_AAAA);
        tick();

`ifdef AHB_SRAM_WPROT_EN
        // protected write errors out, protected read is fine
        ap(1'b1, 32'h0000_0040, SW);
        settle();
        check("wp_ap_cs", 32'(sram_cs), 32'd0);
        tick();
        hwdata = 32'h0000_0001;
        idle();
        settle();
        check("wp_e1_resp", 32'(hresp), 32'd1);
        check("wp_e1_rdy", 32'(hreadyout), 32'd0);
        check("wp_e1_we", 32'(sram_we), 32'd0);
        tick();
        settle();
        check("wp_e2_resp", 32'(hresp), 32'd1);
        tick();
        ap(1'b0, 32'h0000_0040, SW);
        settle();
        check("wp_rd_cs", 32'(sram_cs), 32'd1);
        tick();
        idle();
        settle();
        check("wp_rd_resp", 32'(hresp), 32'd0);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite responder. It accepts transfers from the bus master and drives one single-port synchronous SRAM with a 32-bit word width.
- It is the counterpart of the team's AHB master BFM and the core of the ahb2sram bridge.
- Normal transfers complete with zero wait states. A read issued directly after a write costs one wait state.
- It returns a two-cycle ERROR response for illegal transfers.

Parameters:
- MEM_WORDS, 1024: SRAM depth in 32-bit words; must be a power of 2.
- SRAM_AW, 10: SRAM word-address width; must equal log2(MEM_WORDS).
- WPROT_TOP, 32'h0000_0100: byte address below which writes are illegal. Used only when AHB_SRAM_WPROT_EN is defined.

Ports:
- hclk  in  1  clock
- rst  in  1  synchronous reset, active-high
- hsel  in  1  slave select
- haddr  in  32  byte address
- hwrite  in  1  1 = write
- htrans  in  2  IDLE/BUSY/NONSEQ/SEQ
- hsize  in  3  BYTE/HALF/WORD
- hburst  in  3  burst type; ignored
- hwdata  in  32  write data; valid in the data phase
- hready  in  1  bus-level ready
- hreadyout  out  1  slave ready
- hresp  out  1  0 = OKAY, 1 = ERROR
- hrdata  out  32  read data
- sram_cs  out  1  SRAM chip select
- sram_we  out  1  SRAM write enable
- sram_addr  out  SRAM_AW  SRAM word address
- sram_be  out  4  SRAM byte enables
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, one cycle after a read cs

Behaviour:
- Reset (synchronous, any state):
  - State goes to IDLE; hreadyout=1; hresp=0.
  - sram_cs=0, sram_we=0, sram_be=0.
  - Captured address, size and flags are cleared.
  - Any in-flight data phase is abandoned and no SRAM write is issued.
- Address-phase accept: acc = hsel & htrans[1] & hready. SEQ and NONSEQ are handled identically; every beat is independent.
- BUSY, IDLE, or hsel=0: give an OKAY zero-wait response; no SRAM access.
- Illegal transfer, when any of these holds:
  - hsize > WORD;
  - misaligned: HALF with haddr[0]=1, or WORD with haddr[1:0]!=0;
  - haddr[31:2] >= MEM_WORDS.
- Error response: state ERR1 then ERR2.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
  - No SRAM access occurs.
- Read:
  - On the acc cycle, drive sram_cs=1, sram_we=0, sram_addr=haddr[SRAM_AW+1:2] combinationally.
  - Next cycle is state RD_DATA: hrdata=sram_rdata, hreadyout=1, hresp=0 (zero wait).
- Write:
  - On acc, register the address, hsize and haddr[1:0], then go to WR_DATA.
  - In WR_DATA: sram_cs=1, sram_we=1, sram_addr=registered address, sram_wdata=hwdata, sram_be from the registered size/offset.
  - Byte enables are little-endian: BYTE gives 4'b0001<<off; HALF gives 4'b0011<<off; WORD gives 4'b1111.
- Read-after-write collision: a read acc presented during WR_DATA.
  - The write owns the SRAM in that cycle; hreadyout=0 and the state goes to WR_STALL.
  - In WR_STALL: no SRAM write (the write was issued exactly once); hreadyout=1; the held read is issued to the SRAM in this cycle; next state is RD_DATA.
- Write-after-write and write-after-read: zero wait. WR_DATA to WR_DATA with back-to-back SRAM writes is legal.
- hrdata holds its last value outside RD_DATA. hresp=0 in all states except ERR1 and ERR2.
- A new acc during ERR2 is accepted normally.
- States: IDLE, RD_DATA, WR_DATA, WR_STALL, ERR1, ERR2. The next state on acc is decided by the transfer type and legality.

Optional Feature:
- AHB_SRAM_WPROT_EN
  - Defined: a write with haddr < WPROT_TOP is illegal and takes the ERR1/ERR2 path with no SRAM write. Reads of that region are allowed.
  - Undefined: no write protection; WPROT_TOP is unused.

Decomposition:
- Package ahb_pkg holds:
  - htrans codes (IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11);
  - hsize codes (BYTE 3'b000, HALF 3'b001, WORD 3'b010);
  - hresp codes (OKAY, ERROR);
  - the FSM state encoding.
- One sub-module, ahb_sram_be_gen: combinational hsize/offset to sram_be plus a misalignment flag. It is reused by future AHB peripherals.

Test Plan:
- Write WORD 0x10=0xDEADBEEF, then read 0x10 → the write has sram_be=4'hF; the read takes 1 wait state; hrdata=0xDEADBEEF, hresp=0.
- Write BYTE 0x13=0xAB into a word preloaded with 0x11223344 → sram_be=4'b1000; a later read returns 0xAB223344 with zero wait states.
- Read address 0x1000 with MEM_WORDS=1024, and WORD write 0x22 → each gives hresp=1 for 2 cycles with hreadyout 0 then 1; sram_cs stays 0.
- Back-to-back writes 0x0/0x4/0x8, then reads of 0x0/0x4/0x8 → no wait states except the single one at the write-to-read boundary; data matches.
- Assert rst in a WR_DATA cycle → sram_we=0 in the following cycle; hreadyout=1, hresp=0; the word stays unchanged.
- With AHB_SRAM_WPROT_EN defined: write 0x40=0x1 → ERROR response, memory unchanged; read 0x40 → OKAY.
